// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte register file behind an auto-incrementing register pointer.
// Bus pins are synchronised to clk and every bus decision is taken on a detected SCL edge.
module i2c_slave_regfile #(
    parameter int                  ADDR_BIT    = 7,
    parameter logic [ADDR_BIT-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                  N_REGS      = 16,
    parameter int                  SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      scl,
    inout  wire                       sda,
    input  logic [$clog2(N_REGS)-1:0] host_idx,
    output logic [7:0]                host_rdata,
    output logic                      wr_stb,
    output logic [$clog2(N_REGS)-1:0] wr_idx,
    output logic [7:0]                wr_data,
    output logic                      busy
);

    // state     | meaning
    // IDLE      | bus free or not yet addressed
    // ADDR      | shifting in address + R/W byte
    // ACK_ADDR  | acknowledging our address
    // WR_PTR    | shifting in register pointer byte
    // ACK_PTR   | acknowledging pointer byte
    // WR_DATA   | shifting in a data byte for reg[ptr]
    // ACK_DATA  | acknowledging a data byte
    // RD_DATA   | shifting out reg[ptr]
    // RD_ACK    | sampling master ACK/NACK
    // WAIT_STOP | not addressed or read finished; wait for START/STOP

    localparam int IDX_W = $clog2(N_REGS);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, WR_PTR, ACK_PTR, WR_DATA, ACK_DATA, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic                   scl_rise, scl_fall, start_det, stop_det;

    state_t                 state;
    logic [3:0]             bitcnt;
    logic [7:0]             shift;
    logic [7:0]             rx_byte;
    logic                   rw;
    logic [IDX_W-1:0]       ptr;
    logic [7:0]             regs [N_REGS];
    logic                   sda_oe;

    assign sda = sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte   = {shift[6:0], sda_s};

    assign host_rdata = regs[host_idx];

    // In ACK states bitcnt==8 means "ACK not yet driven", bitcnt==0 means "ACK slot clocked".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bitcnt  <= 4'd0;
            shift   <= 8'd0;
            rw      <= 1'b0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_idx  <= '0;
            wr_data <= 8'd0;
            for (int i = 0; i < N_REGS; i++) regs[i] <= 8'd0;
        end else begin
            wr_stb <= 1'b0;
            if (start_det) begin
                state  <= ADDR;
                bitcnt <= 4'd0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                bitcnt <= 4'd0;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (scl_rise) begin
                        shift  <= rx_byte;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            if (rx_byte[7 -: ADDR_BIT] == SLAVE_ADDR) begin
                                state <= ACK_ADDR;
                                busy  <= 1'b1;
                                rw    <= rx_byte[0];
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    WR_PTR: if (scl_rise) begin
                        shift  <= rx_byte;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            ptr   <= rx_byte[IDX_W-1:0];
                            state <= ACK_PTR;
                        end
                    end
                    WR_DATA: if (scl_rise) begin
                        shift  <= rx_byte;
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd7) begin
                            regs[ptr] <= rx_byte;
                            wr_stb    <= 1'b1;
                            wr_idx    <= ptr;
                            wr_data   <= rx_byte;
                            ptr       <= ptr + IDX_W'(1);
                            state     <= ACK_DATA;
                        end
                    end
                    ACK_ADDR, ACK_PTR, ACK_DATA: begin
                        if (scl_rise) begin
                            bitcnt <= 4'd0;
                        end else if (scl_fall) begin
                            if (bitcnt == 4'd8) begin
                                sda_oe <= 1'b1;
                            end else begin
                                bitcnt <= 4'd0;
                                sda_oe <= 1'b0;
                                if (state == ACK_ADDR && rw) begin
                                    shift  <= regs[ptr];
                                    sda_oe <= ~regs[ptr][7];
                                    state  <= RD_DATA;
                                end else if (state == ACK_ADDR) begin
                                    state <= WR_PTR;
                                end else begin
                                    state <= WR_DATA;
                                end
                            end
                        end
                    end
                    RD_DATA: begin
                        if (scl_rise) begin
                            bitcnt <= bitcnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bitcnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= RD_ACK;
                            end else begin
                                sda_oe <= ~shift[3'd7 - bitcnt[2:0]];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ptr    <= ptr + IDX_W'(1);
                            bitcnt <= 4'd0;
                            if (sda_s) begin
                                state <= WAIT_STOP;
                                busy  <= 1'b0;
                            end
                        end else if (scl_fall && bitcnt == 4'd0) begin
                            shift  <= regs[ptr];
                            sda_oe <= ~regs[ptr][7];
                            state  <= RD_DATA;
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bus-level bench for i2c_slave_regfile: bit-banged I2C master plus a register-file model.
module tb_i2c_slave_regfile;

    localparam int         Q     = 6;
    localparam logic [6:0] SADDR = 7'h50;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl     = 1'b1;
    logic       m_low   = 1'b0;
    wire        sda;
    logic [3:0] host_idx = 4'd0;
    logic [7:0] host_rdata;
    logic       wr_stb;
    logic [3:0] wr_idx;
    logic [7:0] wr_data;
    logic       busy;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_regfile dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl        (scl),
        .sda        (sda),
        .host_idx   (host_idx),
        .host_rdata (host_rdata),
        .wr_stb     (wr_stb),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] mem [16];
    int         mptr;

    int         got_idx [$];
    logic [7:0] got_data [$];
    int         slave_low = 0;
    int         busy_hi   = 0;

    always @(negedge clk) begin
        if (wr_stb) begin
            got_idx.push_back(int'(wr_idx));
            got_data.push_back(wr_data);
        end
        if (sda === 1'b0 && !m_low) slave_low++;
        if (busy) busy_hi++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic qtr();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_low = 1'b0; qtr();
        scl = 1'b1;   qtr();
        m_low = 1'b1; qtr();
        scl = 1'b0;   qtr();
    endtask

    task automatic bus_stop();
        m_low = 1'b1; qtr();
        scl = 1'b1;   qtr();
        m_low = 1'b0; qtr();
    endtask

    task automatic put_bit(input logic b);
        m_low = ~b; qtr();
        scl = 1'b1; qtr(); qtr();
        scl = 1'b0; qtr();
    endtask

    task automatic get_bit(output logic b);
        m_low = 1'b0; qtr();
        scl = 1'b1;   qtr();
        b = sda;      qtr();
        scl = 1'b0;   qtr();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        d = 8'd0;
        for (int i = 0; i < 8; i++) begin
            get_bit(b);
            d = {d[6:0], b};
        end
        put_bit(nack);
    endtask

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            host_idx = 4'(i);
            #1;
            chk($sformatf("%s/reg%0d", tag, i), host_rdata, mem[i]);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "/busy"}, busy, 0);
        chk({tag, "/sda"}, sda, 1);
    endtask

    task automatic txn_write(input logic [6:0] a, input logic [7:0] p, input logic [7:0] data [$],
                             input string tag);
        logic       ack;
        logic       match;
        int         s0, b0, g0;
        int         e_idx [$];
        logic [7:0] e_dat [$];
        match = (a == SADDR);
        s0 = slave_low; b0 = busy_hi; g0 = got_idx.size();
        bus_start();
        write_byte({a, 1'b0}, ack);
        chk({tag, "/ack_addr"}, ack, match ? 0 : 1);
        chk({tag, "/busy_addr"}, busy, match ? 1 : 0);
        write_byte(p, ack);
        chk({tag, "/ack_ptr"}, ack, match ? 0 : 1);
        if (match) mptr = p % 16;
        foreach (data[k]) begin
            write_byte(data[k], ack);
            chk({tag, "/ack_data"}, ack, match ? 0 : 1);
            if (match) begin
                mem[mptr] = data[k];
                e_idx.push_back(mptr);
                e_dat.push_back(data[k]);
                mptr = (mptr + 1) % 16;
            end
        end
        bus_stop();
        chk_idle(tag);
        if (!match) begin
            chk({tag, "/slave_low"}, slave_low - s0, 0);
            chk({tag, "/busy_seen"}, busy_hi - b0, 0);
        end
        chk({tag, "/wr_cnt"}, got_idx.size() - g0, e_idx.size());
        for (int k = 0; k < e_idx.size() && g0 + k < got_idx.size(); k++) begin
            chk({tag, "/wr_idx"}, got_idx[g0 + k], e_idx[k]);
            chk({tag, "/wr_data"}, got_data[g0 + k], e_dat[k]);
        end
    endtask

    task automatic txn_read(input logic set_ptr, input logic [7:0] p, input int n, input string tag);
        logic       ack;
        logic [7:0] d;
        int         g0;
        g0 = got_idx.size();
        bus_start();
        if (set_ptr) begin
            write_byte({SADDR, 1'b0}, ack);
            chk({tag, "/ack_waddr"}, ack, 0);
            write_byte(p, ack);
            chk({tag, "/ack_ptr"}, ack, 0);
            mptr = p % 16;
            bus_start();
        end
        write_byte({SADDR, 1'b1}, ack);
        chk({tag, "/ack_raddr"}, ack, 0);
        for (int k = 0; k < n; k++) begin
            read_byte(d, k == n - 1);
            chk($sformatf("%s/rd%0d", tag, k), d, mem[mptr]);
            mptr = (mptr + 1) % 16;
        end
        chk({tag, "/busy_nack"}, busy, 0);
        bus_stop();
        chk_idle(tag);
        chk({tag, "/wr_cnt"}, got_idx.size() - g0, 0);
    endtask

    task automatic txn_abort(input logic [7:0] p, input string tag);
        logic ack;
        int   g0;
        g0 = got_idx.size();
        bus_start();
        write_byte({SADDR, 1'b0}, ack);
        chk({tag, "/ack_addr"}, ack, 0);
        write_byte(p, ack);
        chk({tag, "/ack_ptr"}, ack, 0);
        mptr = p % 16;
        for (int i = 0; i < 4; i++) put_bit(1'b1);
        bus_stop();
        chk_idle(tag);
        chk({tag, "/wr_cnt"}, got_idx.size() - g0, 0);
    endtask

    initial begin
        logic [7:0] q [$];
        logic       ack;
        int         kind;
        logic [6:0] a;

        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        mptr = 0;

        // reset state
        repeat (4) @(posedge clk);
        #1;
        chk("rst/sda", sda, 1);
        chk("rst/busy", busy, 0);
        chk("rst/wr_stb", wr_stb, 0);
        chk_regs("rst");
        reset_n = 1'b1;
        qtr();

        q = '{8'hA5, 8'h5A};
        txn_write(SADDR, 8'h03, q, "wr");
        chk_regs("wr");

        q = '{};
        txn_write(7'h51, 8'hFF, q, "mis");

        q = '{8'h3C, 8'hC3, 8'h11};
        txn_write(SADDR, 8'h0F, q, "wrap_wr");
        txn_read(1'b1, 8'h0F, 2, "wrap_rd");
        txn_read(1'b0, 8'h00, 1, "ptr_after");

        txn_abort(8'h02, "abort");
        chk_regs("abort");

        for (int it = 0; it < 20; it++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: begin
                    q = '{};
                    for (int k = 0; k < int'($urandom_range(1, 4)); k++) q.push_back(8'($urandom));
                    txn_write(SADDR, 8'($urandom), q, $sformatf("r%0d_wr", it));
                end
                1: txn_read(1'b1, 8'($urandom), int'($urandom_range(1, 4)), $sformatf("r%0d_prd", it));
                2: txn_read(1'b0, 8'h00, int'($urandom_range(1, 3)), $sformatf("r%0d_crd", it));
                3: begin
                    a = 7'($urandom_range(0, 127));
                    if (a == SADDR) a = a ^ 7'h01;
                    q = '{};
                    for (int k = 0; k < int'($urandom_range(0, 2)); k++) q.push_back(8'($urandom));
                    txn_write(a, 8'($urandom), q, $sformatf("r%0d_mis", it));
                end
                default: txn_abort(8'($urandom), $sformatf("r%0d_abt", it));
            endcase
        end
        chk_regs("rand");

        // reset while the slave is holding a 0 data bit
        q = '{8'h12};
        txn_write(SADDR, 8'h05, q, "pre_rst");
        bus_start();
        write_byte({SADDR, 1'b0}, ack);
        write_byte(8'h05, ack);
        bus_start();
        write_byte({SADDR, 1'b1}, ack);
        chk("rst_rd/ack", ack, 0);
        chk("rst_rd/sda_low", sda, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_rd/sda_rel", sda, 1);
        chk("rst_rd/busy", busy, 0);
        chk("rst_rd/wr_stb", wr_stb, 0);
        scl = 1'b1;
        m_low = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        mptr = 0;
        chk_regs("rst_rd");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        qtr();
        txn_read(1'b0, 8'h00, 1, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
